// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued multdiv
// results into one registered register-file write port, squashes queued
// results overtaken by a younger ALU write, and answers hazard lookups.
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  input  logic [4:0]  query_reg,
  output logic        query_pending,
  output logic [31:0] query_data,
  output logic [3:0]  fifo_count
);
  localparam int         PW   = $clog2(DEPTH);
  localparam logic [3:0] FULL = 4'(DEPTH);

  // Occupied slots are exactly the valid ones or squashed ones; a popped
  // slot has its valid bit cleared so stale data never matches a query.
  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [PW-1:0]    head, tail;

  logic md_acc, sel_alu, sel_pop, sel_direct, push;

  // Handshake and output-stage source selection (ALU > FIFO head > direct md)
  always_comb begin
    md_ready   = fifo_count < FULL;
    md_acc     = md_valid && md_ready;
    sel_alu    = alu_valid && (alu_rd != 5'd0);
    sel_pop    = !sel_alu && (fifo_count != 4'd0);
    // !sel_pop already implies the FIFO is empty here
    sel_direct = !sel_alu && !sel_pop && md_acc && (md_rd != 5'd0);
    push       = md_acc && (md_rd != 5'd0) && !sel_direct;
  end

  // Output stage, valid bits, pointers and occupancy
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
      ent_valid        <= '0;
      head             <= '0;
      tail             <= '0;
      fifo_count       <= 4'd0;
    end else begin
      ctrl_writeEnable <= 1'b0;
      if (sel_alu) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= alu_rd;
        data_writeReg    <= alu_data;
      end else if (sel_pop) begin
        ctrl_writeEnable <= ent_valid[head];
        ctrl_writeReg    <= ent_rd[head];
        data_writeReg    <= ent_data[head];
      end else if (sel_direct) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= md_rd;
        data_writeReg    <= md_data;
      end
      // Squash older entries; the push below lands later so a same-cycle
      // entry keeps its valid bit.
      for (int i = 0; i < DEPTH; i++)
        if (sel_alu && ent_rd[i] == alu_rd) ent_valid[i] <= 1'b0;
      if (sel_pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      fifo_count <= fifo_count + {3'b0, push} - {3'b0, sel_pop};
    end
  end

  // Entry payload storage; needs no reset since valid bits gate its use
  always_ff @(posedge clock) begin
    if (push) begin
      ent_rd[tail]   <= md_rd;
      ent_data[tail] <= md_data;
    end
  end

  // Hazard lookup: scan head to tail so the youngest valid match wins,
  // falling back to the output stage when no queued write matches
  always_comb begin
    logic [PW-1:0] idx;
    query_pending = 1'b0;
    query_data    = 32'd0;
    idx           = '0;
    if (query_reg != 5'd0) begin
      if (ctrl_writeEnable && ctrl_writeReg == query_reg) begin
        query_pending = 1'b1;
        query_data    = data_writeReg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PW'(k);
        if (ent_valid[idx] && ent_rd[idx] == query_reg) begin
          query_pending = 1'b1;
          query_data    = ent_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  query_reg = '0;
  logic        query_pending;
  logic [31:0] query_data;
  logic [3:0]  fifo_count;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .query_reg(query_reg),
    .query_pending(query_pending), .query_data(query_data),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of pending multdiv writes plus the write port
  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
  } ent_t;
  ent_t      mq[$];
  bit        m_we;
  bit [4:0]  m_wr;
  bit [31:0] m_wd;

  task automatic model_step(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                            input bit mv, input bit [4:0] mr, input bit [31:0] mdd);
    bit   acc;
    bit   keep;
    ent_t e;
    acc  = mv && (mq.size() < DEPTH);
    keep = acc && (mr != 0);
    if (av && ar != 0) begin
      m_we = 1; m_wr = ar; m_wd = ad;
      foreach (mq[i]) if (mq[i].rd == ar) mq[i].v = 0;
      if (keep) mq.push_back('{1'b1, mr, mdd});
    end else if (mq.size() != 0) begin
      e = mq.pop_front();
      m_we = e.v; m_wr = e.rd; m_wd = e.d;
      if (keep) mq.push_back('{1'b1, mr, mdd});
    end else if (keep) begin
      m_we = 1; m_wr = mr; m_wd = mdd;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    bit        qp;
    bit [31:0] qd;
    qp = 0; qd = 0;
    if (query_reg != 0) begin
      for (int i = mq.size() - 1; i >= 0 && !qp; i--)
        if (mq[i].v && mq[i].rd == query_reg) begin qp = 1; qd = mq[i].d; end
      if (!qp && m_we && m_wr == query_reg) begin qp = 1; qd = m_wd; end
    end
    chk({tag, ".md_ready"}, 32'(md_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".count"},    32'(fifo_count), 32'(mq.size()));
    chk({tag, ".we"},       32'(ctrl_writeEnable), 32'(m_we));
    chk({tag, ".wreg"},     32'(ctrl_writeReg), 32'(m_wr));
    chk({tag, ".wdata"},    data_writeReg, m_wd);
    chk({tag, ".qpend"},    32'(query_pending), 32'(qp));
    chk({tag, ".qdata"},    query_data, qd);
  endtask

  task automatic drive_step(input string tag,
                            input bit av, input bit [4:0] ar, input bit [31:0] ad,
                            input bit mv, input bit [4:0] mr, input bit [31:0] mdd,
                            input bit [4:0] qr);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    md_valid = mv; md_rd = mr; md_data = mdd; query_reg = qr;
    #1 check_outs(tag);
    @(posedge clock);
    model_step(av, ar, ad, mv, mr, mdd);
  endtask

  task automatic cycle(input string tag,
                       input bit av, input bit [4:0] ar, input bit [31:0] ad,
                       input bit mv, input bit [4:0] mr, input bit [31:0] mdd,
                       input bit [4:0] qr);
    @(negedge clock);
    drive_step(tag, av, ar, ad, mv, mr, mdd, qr);
  endtask

  task automatic idle(input string tag, input int n, input bit [4:0] qr);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, qr);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".we"},       32'(ctrl_writeEnable), 32'd0);
    chk({tag, ".wreg"},     32'(ctrl_writeReg), 32'd0);
    chk({tag, ".wdata"},    data_writeReg, 32'd0);
    chk({tag, ".count"},    32'(fifo_count), 32'd0);
    chk({tag, ".qpend"},    32'(query_pending), 32'd0);
    chk({tag, ".qdata"},    query_data, 32'd0);
    chk({tag, ".md_ready"}, 32'(md_ready), 32'd1);
  endtask

  initial begin
    m_we = 0; m_wr = 0; m_wd = 0;
    // Power-on reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    query_reg = 5'd5;
    #1 check_reset_state("por");
    @(negedge clock);
    ctrl_reset = 1'b0;

    // ALU only: one write then idle
    cycle("alu", 1, 5, 32'h11, 0, 0, 0, 5);
    idle("alu_idle", 2, 5);

    // Conflict: ALU wins, md waits one cycle in the FIFO
    cycle("conf", 1, 3, 32'h33, 1, 4, 32'h44, 4);
    idle("conf_drain", 3, 4);

    // Full: ALU hogs the port while md fills the FIFO
    for (int i = 0; i < 6; i++)
      cycle("full", 1, 1, 32'h100 + i, 1, 5'(8 + i), 32'h800 + i, 5'(8 + (i % 4)));
    idle("full_drain", 6, 10);

    // Squash: queued r7 overtaken by ALU r7
    cycle("sq_q", 1, 2, 32'h2, 1, 7, 32'hA, 7);
    cycle("sq_alu", 1, 7, 32'hB, 0, 0, 0, 7);
    idle("sq_drain", 3, 7);

    // Register 0 and query
    cycle("r0", 0, 0, 0, 1, 0, 32'hDEAD, 0);
    cycle("r0_alu", 1, 0, 32'hBEEF, 0, 0, 0, 0);
    cycle("q9", 1, 2, 32'h22, 1, 9, 32'h55, 9);
    cycle("q9b", 0, 0, 0, 0, 0, 0, 9);
    idle("q9_drain", 2, 9);

    // Reset mid-run with three queued entries
    for (int i = 0; i < 3; i++)
      cycle("pre_rst", 1, 1, 32'h7, 1, 5'(12 + i), 32'hC0 + i, 12);
    @(negedge clock);
    ctrl_reset = 1'b1;
    alu_valid = 0; md_valid = 0; query_reg = 5'd13;
    #1 check_reset_state("midrst");
    mq.delete(); m_we = 0; m_wr = 0; m_wd = 0;
    @(negedge clock);
    #1 check_reset_state("midrst_hold");
    @(negedge clock);
    ctrl_reset = 1'b0;
    // First edge after release takes the handshake straight to the port
    drive_step("post_rst", 0, 0, 0, 1, 6, 32'h66, 12);
    idle("post_rst_idle", 3, 6);

    // Random traffic with a narrow register range to force collisions
    for (int n = 0; n < 600; n++) begin
      bit        av, mv;
      bit [4:0]  ar, mr, qr;
      av = ($urandom_range(0, 99) < 50);
      mv = ($urandom_range(0, 99) < 65);
      ar = 5'($urandom_range(0, 12));
      mr = 5'($urandom_range(0, 12));
      qr = 5'($urandom_range(0, 12));
      cycle("rnd", av, ar, $urandom, mv, mr, $urandom, qr);
    end
    idle("rnd_drain", 6, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
